memory_dp: RTL
==============

MEMORY_DP -- requirements
Module: memory_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width in bits.
REQ-003 SHALL have parameter MEMO_DEPTH, default (1 << ADDR_WIDTH): number of words.
REQ-004 SHALL have parameter RD_LATENCY, default 1: read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL provide port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL provide port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL provide port Wr_en, input, 1 bit: write request.
REQ-008 SHALL provide port Wr_addr, input, ADDR_WIDTH bits: write address.
REQ-009 SHALL provide port Wr_data, input, DATA_WIDTH bits: write data.
REQ-010 SHALL provide port Byte_en, input, DATA_WIDTH/8 bits: per-byte write mask; bit k enables bits [8k+7:8k].
REQ-011 SHALL provide port Rd_en, input, 1 bit: read request.
REQ-012 SHALL provide port Rd_addr, input, ADDR_WIDTH bits: read address.
REQ-013 SHALL provide port Clr, input, 1 bit: single-cycle pulse that starts a sequential clear of the whole array.
REQ-014 SHALL provide port Data_out, output, DATA_WIDTH bits: read data.
REQ-015 SHALL provide port Valid_out, output, 1 bit: Data_out is valid this cycle.
REQ-016 SHALL provide port Busy, output, 1 bit: a sequential clear is in progress.

Function
REQ-017 SHALL accept one write and one read in the same cycle, on independent ports.
REQ-018 SHALL, on Wr_en=1 while not Busy, update only the bytes of mem[Wr_addr] whose Byte_en bit is 1; all other bytes keep their value.
REQ-019 SHALL, on Rd_en=1 while not Busy, present mem[Rd_addr] on Data_out with Valid_out=1 exactly RD_LATENCY rising edges after the request.
REQ-020 SHALL hold Data_out at its last value and drive Valid_out=0 in every cycle with no read completing.
REQ-021 SHALL, when a read and a write target the same address in the same cycle, return the merged word (write-first): new bytes where Byte_en=1, old bytes elsewhere.
REQ-022 SHALL, with RD_LATENCY=2, pipeline both data and valid so that back-to-back reads complete back-to-back, one per cycle.
REQ-023 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-024 SHALL go IDLE->CLEAR on Clr=1; the clear counter starts at 0.
REQ-025 SHALL, in CLEAR, zero one word per cycle at addresses 0..MEMO_DEPTH-1, then return to IDLE; Busy=1 for exactly MEMO_DEPTH cycles.
REQ-026 SHALL, while Busy, ignore Wr_en, Rd_en and Clr; reads already in the RD_LATENCY pipeline when the clear starts still complete.
REQ-027 SHALL give Clr priority over a Wr_en/Rd_en in the same cycle: that write and that read are dropped.
REQ-028 SHALL make the clear counter exactly ADDR_WIDTH bits wide and end the clear on the terminal count MEMO_DEPTH-1, with no wrap-around re-clear.

Reset
REQ-029 SHALL, on RST=1, immediately and asynchronously force Data_out=0, Valid_out=0, Busy=0, FSM=IDLE, clear counter=0, and empty the read pipeline.
REQ-030 SHALL, on RST=1, zero every memory word, including when reset asserts mid-clear or mid-read.
REQ-031 SHALL accept a request on the first rising edge after RST deasserts.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE, CLEAR) and the legal RD_LATENCY values in the shared package memory_pkg.
REQ-033 SHALL compute the byte-merge (old word, new data, Byte_en -> merged word) in one sub-module, byte_merge, used by both the write path and the bypass path.

Verification
REQ-034 SHALL cover reset: RST pulse -> Data_out=0, Valid_out=0, Busy=0, and a read of addresses 0..15 returns 0.
REQ-035 SHALL cover byte-enable write and read: write 0xAABBCCDD to addr 3 with Byte_en=4'b1111, then write 0x11223344 to addr 3 with Byte_en=4'b0101, then read addr 3 -> 0xAA22CC44 with Valid_out=1 exactly RD_LATENCY cycles later.
REQ-036 SHALL cover read/write collision: mem[5]=0x0 and, in the same cycle, write 0xFFFF0000 with Byte_en=4'b1100 while reading addr 5 -> Data_out=0xFFFF0000.
REQ-037 SHALL cover clear: fill all 16 words with nonzero values, pulse Clr -> Busy=1 for 16 cycles, writes during Busy are ignored, and all words read 0 afterwards.
REQ-038 SHALL cover RD_LATENCY=2: reads of addrs 0,1,2 on consecutive cycles -> three consecutive valid outputs starting 2 cycles after the first read.
REQ-039 SHALL cover reset mid-clear: assert RST at cycle 7 of a clear -> Busy=0 immediately and all words read 0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and constants for the dual-port byte-enable memory.
package memory_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Legal read latencies
    localparam int unsigned RD_LAT_ONE = 1;
    localparam int unsigned RD_LAT_TWO = 2;

    // True when a read latency value is supported
    function automatic logic rd_latency_legal(input int unsigned lat);
        return (lat == RD_LAT_ONE) || (lat == RD_LAT_TWO);
    endfunction

endpackage : memory_pkg

// File: rtl/byte_merge.sv
// Combines an existing word with new data under a per-byte enable mask.
module byte_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]   merged_word_c
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Replace each enabled byte lane with the new data
    always_comb begin
        merged_word_c = old_word;
        for (int unsigned k = 0; k < BE_WIDTH; k++) begin
            if (byte_en[k]) begin
                merged_word_c[8*k +: 8] = new_data[8*k +: 8];
            end
        end
    end

endmodule : byte_merge

// File: rtl/memory_dp.sv
// Dual-port (1W/1R) byte-enable memory with write-first bypass,
// 1- or 2-cycle read latency and a sequential whole-array clear.
module memory_dp
    import memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEMO_DEPTH = (1 << ADDR_WIDTH),
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Wr_en,
    input  logic [ADDR_WIDTH-1:0]   Wr_addr,
    input  logic [DATA_WIDTH-1:0]   Wr_data,
    input  logic [DATA_WIDTH/8-1:0] Byte_en,
    input  logic                    Rd_en,
    input  logic [ADDR_WIDTH-1:0]   Rd_addr,
    input  logic                    Clr,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    Valid_out,
    output logic                    Busy
);

    localparam int unsigned ADDR_EXT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = ADDR_EXT_W'(MEMO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMO_DEPTH - 1);
    // Any unsupported latency is built as the two-stage pipeline
    localparam logic LAT_TWO = !rd_latency_legal(RD_LATENCY) || (RD_LATENCY == RD_LAT_TWO);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEMO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEMO_DEPTH];
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    valid_q, valid_d;

    logic                    idle_c;
    logic                    wr_acc_c;
    logic                    rd_acc_c;
    logic                    bypass_c;
    logic [DATA_WIDTH-1:0]   merged_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    // Request qualification: only in IDLE and never alongside a clear pulse
    always_comb begin
        idle_c   = (state_q == ST_IDLE);
        wr_acc_c = idle_c && Wr_en && !Clr && ({1'b0, Wr_addr} < DEPTH_EXT);
        rd_acc_c = idle_c && Rd_en && !Clr;
        bypass_c = wr_acc_c && (Wr_addr == Rd_addr);
    end

    // One merge serves both the array update and the same-address bypass
    byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .old_word      (mem_q[Wr_addr]),
        .new_data      (Wr_data),
        .byte_en       (Byte_en),
        .merged_word_c (merged_c)
    );

    // Read word selection with write-first bypass; out-of-range reads return zero
    always_comb begin
        rd_word_c = '0;
        if (bypass_c) begin
            rd_word_c = merged_c;
        end else if ({1'b0, Rd_addr} < DEPTH_EXT) begin
            rd_word_c = mem_q[Rd_addr];
        end
    end

    // Clear sequencer next-state: counts 0..MEMO_DEPTH-1 then returns to IDLE
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Clear sequencer state and counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array next-state: accepted byte write, or one zeroed word per clear cycle
    always_comb begin
        mem_d = mem_q;
        if (wr_acc_c) begin
            mem_d[Wr_addr] = merged_c;
        end
        if (state_q == ST_CLEAR) begin
            mem_d[clr_cnt_q] = '0;
        end
    end

    // Storage array, fully zeroed by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < MEMO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read pipeline: data is captured at request time, so in-flight reads
    // finish even if a clear starts behind them
    generate
        if (LAT_TWO) begin : gen_lat2
            logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
            logic                  s1_vld_q,  s1_vld_d;

            // Stage-1 capture and output stage hold
            always_comb begin
                s1_vld_d   = rd_acc_c;
                s1_data_d  = rd_acc_c ? rd_word_c : s1_data_q;
                valid_d    = s1_vld_q;
                data_out_d = s1_vld_q ? s1_data_q : data_out_q;
            end

            // Stage-1 registers
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q  <= s1_vld_d;
                    s1_data_q <= s1_data_d;
                end
            end
        end else begin : gen_lat1
            // Single-stage capture with output hold
            always_comb begin
                valid_d    = rd_acc_c;
                data_out_d = rd_acc_c ? rd_word_c : data_out_q;
            end
        end
    endgenerate

    // Output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign Data_out  = data_out_q;
    assign Valid_out = valid_q;
    assign Busy      = (state_q == ST_CLEAR);

endmodule : memory_dp
